// File: rtl/veda_mem_arbiter.sv
// Round-robin arbiter/sequencer that serialises two single-word requesters onto the
// VEDA_data memory port, returning read data with a one-cycle valid pulse.
module veda_mem_arbiter #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_a_i,
  input  logic              we_a_i,
  input  logic [ADDR_W-1:0] addr_a_i,
  input  logic [DATA_W-1:0] wdata_a_i,
  output logic              gnt_a_o,
  output logic              rvalid_a_o,
  output logic [DATA_W-1:0] rdata_a_o,
  input  logic              req_b_i,
  input  logic              we_b_i,
  input  logic [ADDR_W-1:0] addr_b_i,
  input  logic [DATA_W-1:0] wdata_b_i,
  output logic              gnt_b_o,
  output logic              rvalid_b_o,
  output logic [DATA_W-1:0] rdata_b_o,
  output logic              mem_w_en_o,
  output logic              mem_mode_o,
  output logic [ADDR_W-1:0] mem_address_o,
  output logic [DATA_W-1:0] mem_datain_o,
  input  logic [DATA_W-1:0] mem_dataout_i,
  output logic              busy_o,
  output logic [CNT_W-1:0]  conflict_cnt_o
);

  typedef enum logic [1:0] {IDLE, ISSUE, RWAIT, RESP} state_e;

  state_e              state_q, state_d;
  logic                last_b_q, last_b_d;    // 1: B won the most recent tie
  logic                owner_b_q, owner_b_d;  // requester owning the current access
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                gnt_a_q, gnt_a_d, gnt_b_q, gnt_b_d;
  logic                rvalid_a_q, rvalid_a_d, rvalid_b_q, rvalid_b_d;
  logic [DATA_W-1:0]   rdata_a_q, rdata_a_d, rdata_b_q, rdata_b_d;
  logic                mem_w_en_q, mem_w_en_d, mem_mode_q, mem_mode_d;
  logic [ADDR_W-1:0]   mem_address_q, mem_address_d;
  logic [DATA_W-1:0]   mem_datain_q, mem_datain_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                win_b;

  always_comb begin
    // NOTE: every next-state value gets a default first, so no branch can infer a latch.
    state_d       = state_q;
    last_b_d      = last_b_q;
    owner_b_d     = owner_b_q;
    we_d          = we_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    gnt_a_d       = 1'b0;
    gnt_b_d       = 1'b0;
    rvalid_a_d    = 1'b0;
    rvalid_b_d    = 1'b0;
    rdata_a_d     = rdata_a_q;
    rdata_b_d     = rdata_b_q;
    mem_w_en_d    = 1'b0;
    mem_mode_d    = 1'b0;
    mem_address_d = '0;
    mem_datain_d  = '0;
    cnt_d         = cnt_q;
    win_b         = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (req_a_i || req_b_i) begin
          win_b     = req_b_i && (!req_a_i || !last_b_q);
          owner_b_d = win_b;
          we_d      = win_b ? we_b_i    : we_a_i;
          addr_d    = win_b ? addr_b_i  : addr_a_i;
          wdata_d   = win_b ? wdata_b_i : wdata_a_i;
          gnt_a_d   = !win_b;
          gnt_b_d   = win_b;
          if (req_a_i && req_b_i) begin
            last_b_d = win_b;
            if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
          end
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        // Memory controls are registered, so they appear in the cycle after ISSUE.
        mem_w_en_d    = 1'b1;
        mem_mode_d    = we_q;
        mem_address_d = addr_q;
        mem_datain_d  = we_q ? wdata_q : '0;
        state_d       = we_q ? IDLE : RWAIT;
      end
      RWAIT: state_d = RESP;
      RESP: begin
        if (owner_b_q) begin
          rvalid_b_d = 1'b1;
          rdata_b_d  = mem_dataout_i;
        end else begin
          rvalid_a_d = 1'b1;
          rdata_a_d  = mem_dataout_i;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      last_b_q      <= 1'b1;
      owner_b_q     <= 1'b0;
      we_q          <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      gnt_a_q       <= 1'b0;
      gnt_b_q       <= 1'b0;
      rvalid_a_q    <= 1'b0;
      rvalid_b_q    <= 1'b0;
      rdata_a_q     <= '0;
      rdata_b_q     <= '0;
      mem_w_en_q    <= 1'b0;
      mem_mode_q    <= 1'b0;
      mem_address_q <= '0;
      mem_datain_q  <= '0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      last_b_q      <= last_b_d;
      owner_b_q     <= owner_b_d;
      we_q          <= we_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      gnt_a_q       <= gnt_a_d;
      gnt_b_q       <= gnt_b_d;
      rvalid_a_q    <= rvalid_a_d;
      rvalid_b_q    <= rvalid_b_d;
      rdata_a_q     <= rdata_a_d;
      rdata_b_q     <= rdata_b_d;
      mem_w_en_q    <= mem_w_en_d;
      mem_mode_q    <= mem_mode_d;
      mem_address_q <= mem_address_d;
      mem_datain_q  <= mem_datain_d;
      cnt_q         <= cnt_d;
    end
  end

  assign gnt_a_o        = gnt_a_q;
  assign gnt_b_o        = gnt_b_q;
  assign rvalid_a_o     = rvalid_a_q;
  assign rvalid_b_o     = rvalid_b_q;
  assign rdata_a_o      = rdata_a_q;
  assign rdata_b_o      = rdata_b_q;
  assign mem_w_en_o     = mem_w_en_q;
  assign mem_mode_o     = mem_mode_q;
  assign mem_address_o  = mem_address_q;
  assign mem_datain_o   = mem_datain_q;
  assign busy_o         = (state_q != IDLE);
  assign conflict_cnt_o = cnt_q;

endmodule

// File: tb/tb_veda_mem_arbiter.sv
// Bench for veda_mem_arbiter: transaction-level reference model with a registered
// VEDA_data emulation; a second instance with a 4-bit counter checks saturation.
module tb_veda_mem_arbiter;
  localparam int AW = 9;
  localparam int DW = 32;

  logic clk = 1'b0, rst_n = 1'b0;
  logic req_a = 1'b0, we_a = 1'b0, req_b = 1'b0, we_b = 1'b0;
  logic [AW-1:0] addr_a = '0, addr_b = '0;
  logic [DW-1:0] wdata_a = '0, wdata_b = '0;

  logic gnt_a, rvalid_a, gnt_b, rvalid_b, mem_w_en, mem_mode, busy;
  logic [DW-1:0] rdata_a, rdata_b, mem_datain, mem_dataout;
  logic [AW-1:0] mem_address;
  logic [15:0]   conflict_cnt;

  logic s_gnt_a, s_rvalid_a, s_gnt_b, s_rvalid_b, s_mem_w_en, s_mem_mode, s_busy;
  logic [DW-1:0] s_rdata_a, s_rdata_b, s_mem_datain;
  logic [AW-1:0] s_mem_address;
  logic [3:0]    s_conflict_cnt;

  always #5 clk = ~clk;

  veda_mem_arbiter u_dut (
    .clk(clk), .rst_n(rst_n),
    .req_a_i(req_a), .we_a_i(we_a), .addr_a_i(addr_a), .wdata_a_i(wdata_a),
    .gnt_a_o(gnt_a), .rvalid_a_o(rvalid_a), .rdata_a_o(rdata_a),
    .req_b_i(req_b), .we_b_i(we_b), .addr_b_i(addr_b), .wdata_b_i(wdata_b),
    .gnt_b_o(gnt_b), .rvalid_b_o(rvalid_b), .rdata_b_o(rdata_b),
    .mem_w_en_o(mem_w_en), .mem_mode_o(mem_mode), .mem_address_o(mem_address),
    .mem_datain_o(mem_datain), .mem_dataout_i(mem_dataout),
    .busy_o(busy), .conflict_cnt_o(conflict_cnt)
  );

  veda_mem_arbiter #(.CNT_W(4)) u_sat (
    .clk(clk), .rst_n(rst_n),
    .req_a_i(req_a), .we_a_i(we_a), .addr_a_i(addr_a), .wdata_a_i(wdata_a),
    .gnt_a_o(s_gnt_a), .rvalid_a_o(s_rvalid_a), .rdata_a_o(s_rdata_a),
    .req_b_i(req_b), .we_b_i(we_b), .addr_b_i(addr_b), .wdata_b_i(wdata_b),
    .gnt_b_o(s_gnt_b), .rvalid_b_o(s_rvalid_b), .rdata_b_o(s_rdata_b),
    .mem_w_en_o(s_mem_w_en), .mem_mode_o(s_mem_mode), .mem_address_o(s_mem_address),
    .mem_datain_o(s_mem_datain), .mem_dataout_i(mem_dataout),
    .busy_o(s_busy), .conflict_cnt_o(s_conflict_cnt)
  );

  // VEDA_data emulation: registered read data, garbage whenever no read is in progress.
  logic [DW-1:0] emu_mem [1<<AW];
  initial begin
    for (int i = 0; i < (1<<AW); i++) emu_mem[i] = '0;
    mem_dataout = '0;
    forever begin
      @(posedge clk);
      if (mem_w_en && mem_mode) begin
        emu_mem[mem_address] = mem_datain;
        mem_dataout <= $urandom;
      end else if (mem_w_en) mem_dataout <= emu_mem[mem_address];
      else mem_dataout <= $urandom;
    end
  end

  int n_checks = 0, n_fail = 0;
  int ties;
  logic last_b;
  logic [DW-1:0] ref_mem [1<<AW];
  logic [DW-1:0] exp_rdata_a, exp_rdata_b;

  task automatic model_reset();
    last_b = 1'b1; ties = 0; exp_rdata_a = '0; exp_rdata_b = '0;
  endtask

  task automatic check_cnt(input string name);
    int exp_sat;
    exp_sat = (ties > 15) ? 15 : ties;
    n_checks++;
    if (conflict_cnt !== 16'(ties)) begin
      n_fail++; $display("FAIL %s conflict_cnt: got %0d, expected %0d", name, conflict_cnt, ties);
    end
    n_checks++;
    if (s_conflict_cnt !== 4'(exp_sat)) begin
      n_fail++; $display("FAIL %s conflict_cnt_sat: got %0d, expected %0d", name, s_conflict_cnt, exp_sat);
    end
  endtask

  // Entered at the negedge where the winner's gnt is visible; follows the access to completion.
  task automatic do_txn(input logic is_b, input logic keep);
    logic t_we;
    logic [AW-1:0] t_addr;
    logic [DW-1:0] t_wdata, t_din, t_exp, got_rd, oth_rd, exp_oth;
    t_we    = is_b ? we_b : we_a;
    t_addr  = is_b ? addr_b : addr_a;
    t_wdata = is_b ? wdata_b : wdata_a;
    t_din   = t_we ? t_wdata : '0;
    if (!keep) begin
      if (is_b) req_b = 1'b0; else req_a = 1'b0;
    end
    @(negedge clk);
    n_checks++;
    if (gnt_a !== 1'b0 || gnt_b !== 1'b0) begin
      n_fail++; $display("FAIL gnt_width: got gnt_a=%b gnt_b=%b, expected 0 0", gnt_a, gnt_b);
    end
    n_checks++;
    if (mem_w_en !== 1'b1 || mem_mode !== t_we || mem_address !== t_addr || mem_datain !== t_din) begin
      n_fail++;
      $display("FAIL mem_issue: got en=%b mode=%b addr=%0d din=%h, expected en=1 mode=%b addr=%0d din=%h",
               mem_w_en, mem_mode, mem_address, mem_datain, t_we, t_addr, t_din);
    end
    n_checks++;
    if (busy !== !t_we) begin
      n_fail++; $display("FAIL busy_after_issue: got %b, expected %b", busy, !t_we);
    end
    if (t_we) ref_mem[t_addr] = t_wdata;
    else begin
      t_exp = ref_mem[t_addr];
      @(negedge clk);
      n_checks++;
      if (rvalid_a !== 1'b0 || rvalid_b !== 1'b0 || mem_w_en !== 1'b0 || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL rwait: got rvalid_a=%b rvalid_b=%b mem_w_en=%b busy=%b, expected 0 0 0 1",
                 rvalid_a, rvalid_b, mem_w_en, busy);
      end
      @(negedge clk);
      got_rd  = is_b ? rdata_b : rdata_a;
      oth_rd  = is_b ? rdata_a : rdata_b;
      exp_oth = is_b ? exp_rdata_a : exp_rdata_b;
      n_checks++;
      if ((is_b ? rvalid_b : rvalid_a) !== 1'b1 || (is_b ? rvalid_a : rvalid_b) !== 1'b0) begin
        n_fail++; $display("FAIL rvalid: got rvalid_a=%b rvalid_b=%b, expected owner=%s", rvalid_a, rvalid_b, is_b ? "B" : "A");
      end
      n_checks++;
      if (got_rd !== t_exp) begin
        n_fail++; $display("FAIL rdata addr %0d: got %h, expected %h", t_addr, got_rd, t_exp);
      end
      n_checks++;
      if (oth_rd !== exp_oth) begin
        n_fail++; $display("FAIL rdata_other: got %h, expected %h", oth_rd, exp_oth);
      end
      if (is_b) exp_rdata_b = t_exp; else exp_rdata_a = t_exp;
    end
  endtask

  task automatic wait_gnt(input logic exp_b, input logic keep);
    int lat;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (gnt_a !== 1'b1 && gnt_b !== 1'b1 && lat < 8);
    n_checks++;
    if (gnt_a !== 1'b1 && gnt_b !== 1'b1) begin
      n_fail++; $display("FAIL grant_timeout: got no gnt in %0d cycles, expected gnt_%s", lat, exp_b ? "b" : "a");
    end else begin
      n_checks++;
      if (lat != 1) begin
        n_fail++; $display("FAIL grant_latency: got %0d cycles, expected 1", lat);
      end
      n_checks++;
      if (gnt_b !== exp_b || gnt_a !== !exp_b) begin
        n_fail++; $display("FAIL grant_winner: got gnt_a=%b gnt_b=%b, expected gnt_%s", gnt_a, gnt_b, exp_b ? "b" : "a");
      end
      do_txn(gnt_b, keep);
    end
  endtask

  task automatic run_pattern(input logic ra, input logic rb, input string name);
    logic first_b;
    req_a = ra; req_b = rb;
    if (ra && rb) begin
      first_b = !last_b; last_b = first_b; ties++;
      wait_gnt(first_b, 1'b0);
      wait_gnt(!first_b, 1'b0);
    end else wait_gnt(rb, 1'b0);
    @(negedge clk);
    n_checks++;
    if (gnt_a !== 1'b0 || gnt_b !== 1'b0 || rvalid_a !== 1'b0 || rvalid_b !== 1'b0 ||
        mem_w_en !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s idle_quiet: got gnt=%b%b rvalid=%b%b mem_w_en=%b busy=%b, expected all 0",
               name, gnt_a, gnt_b, rvalid_a, rvalid_b, mem_w_en, busy);
    end
    check_cnt(name);
  endtask

  // Both requests held high throughout; every arbitration is a tie.
  task automatic tie_run(input int n, input string name);
    logic first_b;
    req_a = 1'b1; req_b = 1'b1;
    for (int k = 0; k < n; k++) begin
      first_b = !last_b; last_b = first_b; ties++;
      wait_gnt(first_b, 1'b1);
    end
    req_a = 1'b0; req_b = 1'b0;
    @(negedge clk);
    check_cnt(name);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; req_a = 1'b1; we_a = 1'b0; addr_a = 9'd3; req_b = 1'b0;
    model_reset();
    repeat (3) begin
      @(posedge clk); #1;
      n_checks++;
      if (gnt_a !== 1'b0 || gnt_b !== 1'b0 || rvalid_a !== 1'b0 || rvalid_b !== 1'b0 ||
          mem_w_en !== 1'b0 || mem_mode !== 1'b0 || busy !== 1'b0 || mem_address !== '0 ||
          mem_datain !== '0 || rdata_a !== '0 || rdata_b !== '0 || conflict_cnt !== '0) begin
        n_fail++;
        $display("FAIL reset_state: got gnt=%b%b rvalid=%b%b en=%b mode=%b busy=%b addr=%0d din=%h rd=%h/%h cnt=%0d, expected all 0",
                 gnt_a, gnt_b, rvalid_a, rvalid_b, mem_w_en, mem_mode, busy, mem_address,
                 mem_datain, rdata_a, rdata_b, conflict_cnt);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    wait_gnt(1'b0, 1'b0);
    @(negedge clk);
    check_cnt("reset");
  endtask

  task automatic test_write_read;
    we_a = 1'b1; addr_a = 9'd5; wdata_a = 32'd9;
    run_pattern(1'b1, 1'b0, "a_write");
    we_a = 1'b0;
    run_pattern(1'b1, 1'b0, "a_read");
    we_a = 1'b1; addr_a = 9'h1FF; wdata_a = 32'hA5A5_0001;
    run_pattern(1'b1, 1'b0, "a_write_top");
    we_a = 1'b0;
    run_pattern(1'b1, 1'b0, "a_read_top");
  endtask

  task automatic test_simultaneous;
    we_b = 1'b1; addr_b = 9'd1; wdata_b = 32'h11;
    run_pattern(1'b0, 1'b1, "preload1");
    addr_b = 9'd5; wdata_b = 32'h9;
    run_pattern(1'b0, 1'b1, "preload5");
    we_a = 1'b0; addr_a = 9'd1; we_b = 1'b0; addr_b = 9'd5;
    tie_run(4, "simultaneous");
  endtask

  task automatic test_b_write;
    we_b = 1'b1; addr_b = 9'd1; wdata_b = 32'hDEAD_BEEF;
    run_pattern(1'b0, 1'b1, "b_write");
    n_checks++;
    if (rdata_a !== exp_rdata_a || rvalid_a !== 1'b0) begin
      n_fail++; $display("FAIL a_untouched: got rdata_a=%h rvalid_a=%b, expected %h 0", rdata_a, rvalid_a, exp_rdata_a);
    end
    we_a = 1'b0; addr_a = 9'd1;
    run_pattern(1'b1, 1'b0, "a_read_after_b");
  endtask

  function automatic logic [AW-1:0] pick_addr();
    if ($urandom_range(0, 3) == 0) return AW'($urandom);
    return AW'($urandom_range(0, 15));
  endfunction

  task automatic test_random(input int n);
    logic ra, rb;
    for (int i = 0; i < n; i++) begin
      ra = 1'($urandom_range(0, 1)); rb = 1'($urandom_range(0, 1));
      if (!ra && !rb) ra = 1'b1;
      we_a = 1'($urandom_range(0, 1)); addr_a = pick_addr(); wdata_a = $urandom;
      we_b = 1'($urandom_range(0, 1)); addr_b = pick_addr(); wdata_b = $urandom;
      run_pattern(ra, rb, "random");
    end
  endtask

  task automatic test_reset_mid_read;
    we_a = 1'b1; addr_a = 9'd7; wdata_a = 32'hCAFE_F00D;
    run_pattern(1'b1, 1'b0, "mid_write");
    we_a = 1'b0; req_a = 1'b1;
    @(negedge clk);
    n_checks++;
    if (gnt_a !== 1'b1) begin
      n_fail++; $display("FAIL mid_gnt: got %b, expected 1", gnt_a);
    end
    req_a = 1'b0;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++; $display("FAIL mid_rwait_busy: got %b, expected 1", busy);
    end
    rst_n = 1'b0;
    model_reset();
    repeat (2) begin
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b0 || rvalid_a !== 1'b0 || rdata_a !== '0 || mem_w_en !== 1'b0 || conflict_cnt !== '0) begin
        n_fail++;
        $display("FAIL mid_reset: got busy=%b rvalid_a=%b rdata_a=%h mem_w_en=%b cnt=%0d, expected 0 0 0 0 0",
                 busy, rvalid_a, rdata_a, mem_w_en, conflict_cnt);
      end
    end
    rst_n = 1'b1;
    run_pattern(1'b1, 1'b0, "read_after_reset");
  endtask

  task automatic test_saturation;
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    we_a = 1'b0; addr_a = 9'd1; we_b = 1'b0; addr_b = 9'd5;
    tie_run(20, "saturation");
  endtask

  initial begin
    for (int i = 0; i < (1<<AW); i++) ref_mem[i] = '0;
    test_reset();
    test_write_read();
    test_simultaneous();
    test_b_write();
    test_random(40);
    test_reset_mid_read();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/veda_mem_arbiter.md
Name: veda_mem_arbiter

Overview:
Two-requester arbiter and sequencer in front of the VEDA_data memory (512 x 32, ports clk, w_en, mode, address[8:0], datain[31:0], dataout[31:0]). Requester A is the core load/store unit. Requester B is the program/data loader or debug port. The block serialises their single-word accesses onto the one memory port using round-robin priority, drives the memory control signals for exactly one cycle per access, and returns read data with a valid pulse. It also counts arbitration conflicts.

Parameters:
ADDR_W, 9, memory word-address width
DATA_W, 32, data width
CNT_W, 16, conflict counter width (saturating)

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  synchronous active-low reset
req_a  input  1  requester A access request, held until gnt_a
we_a  input  1  A: 1=write, 0=read
addr_a  input  ADDR_W  A word address
wdata_a  input  DATA_W  A write data
gnt_a  output  1  one-cycle pulse: A request accepted, A fields latched
rvalid_a  output  1  one-cycle pulse: rdata_a valid
rdata_a  output  DATA_W  A read data, held until next A read completes
req_b, we_b, addr_b, wdata_b  input  1/1/ADDR_W/DATA_W  same as A, for requester B
gnt_b, rvalid_b, rdata_b  output  1/1/DATA_W  same as A, for requester B
mem_w_en  output  1  to VEDA_data w_en (access enable)
mem_mode  output  1  to VEDA_data mode: 1=write, 0=read
mem_address  output  ADDR_W  to VEDA_data address
mem_datain  output  DATA_W  to VEDA_data datain
mem_dataout  input  DATA_W  from VEDA_data dataout; registered, valid the cycle after the read access edge
busy  output  1  high in any state other than IDLE
conflict_cnt  output  CNT_W  count of IDLE-state arbitration cycles with both requests high; saturates at all-ones

Behaviour:
- Reset (rst_n=0 at rising edge): state=IDLE; gnt_*, rvalid_*, mem_w_en, mem_mode, busy = 0; mem_address, mem_datain, rdata_a, rdata_b = 0; conflict_cnt=0; last_grant=B, so A wins the first tie. An in-flight access is dropped and no rvalid is issued. Reset dominates all other events.
- FSM states: IDLE, ISSUE, RWAIT, RESP.
- IDLE, no request: stay in IDLE, memory outputs all 0.
- IDLE, any request sampled: select the winner and latch its we/addr/wdata. Assert that requester's gnt for the next cycle only. Go to ISSUE.
- Winner selection: with one request, that requester wins. With both, the requester not in last_grant wins, and last_grant is updated to the winner. On a tie, conflict_cnt += 1 (saturating).
- ISSUE (exactly 1 cycle): mem_w_en=1, mem_mode=latched we, mem_address=latched addr, mem_datain=latched wdata (0 for reads). Next state is IDLE for a write, RWAIT for a read.
- RWAIT (1 cycle): mem_w_en=0. The memory presents data on mem_dataout.
- RESP (entered at the RWAIT->RESP edge): at that edge, capture mem_dataout into the owner's rdata. Assert the owner's rvalid for 1 cycle. Then go to IDLE.
- Read latency: req sampled at edge T0 -> gnt high T0..T1 -> access edge T2 -> rvalid high T3..T4. Write: memory written at edge T2, no response beyond gnt.
- Requests arriving while busy are not sampled. They must stay high and are arbitrated on the first IDLE cycle. There is one idle cycle between back-to-back accesses (IDLE is re-entered each time).
- Requester may drop or change req/fields the cycle after gnt. If req is still high in IDLE, it is a new request.
- Non-owner outputs (gnt, rvalid, rdata) are unaffected by the other requester's transactions.
- Address wrap: none. Addresses are used verbatim; all 2^ADDR_W values are legal.

Test Plan:
1. Reset: hold rst_n=0 for 3 cycles with req_a=1 -> all outputs 0, no gnt. Release -> gnt_a on the first IDLE sample.
2. A write then read: we_a=1, addr_a=5, wdata_a=9 -> gnt_a 1 cycle, mem_w_en=1 / mem_mode=1 / mem_address=5 / mem_datain=9 for 1 cycle. Then A read addr 5 -> rvalid_a 3 cycles after gnt_a start, rdata_a=9.
3. Simultaneous: req_a=req_b=1 continuously, A reads addr 1, B reads addr 5 (preloaded 0x11 / 0x9) -> grants alternate A,B,A,B. Correct rdata on each side. conflict_cnt increments once per arbitration.
4. B write (addr 1, data 0xDEADBEEF) while A is idle -> only gnt_b pulses. A outputs unchanged. A subsequent A read of addr 1 returns 0xDEADBEEF.
5. Reset mid-read: assert rst_n=0 during RWAIT -> no rvalid_a, state IDLE, busy=0. Memory contents intact on the next read.
6. Saturation: force ties with CNT_W=4 for 20 arbitrations -> conflict_cnt stops at 15.
